dmem_responder: RTL and testbench

Data-memory responder for the processor's data bus: the slave end of the DAD/DDT/MREQ/WRITE/SIZE/ACKD_n handshake driven by the pipeline's memory stage. It decodes each request, inserts a programmable number of wait states, then commits a store or returns load data and pulses ACKD_n. It holds a word-organised, big-endian RAM and performs byte-lane steering so that the processor always exchanges right-justified data.

---
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 tb/tb_dmem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the data-bus handshake. It captures a request,
// waits a fixed number of cycles, then either commits a store into a big-endian
// word RAM or returns right-justified load data, and pulses ACKD_n low for one cycle.
//
// Handshake: a request is accepted on any rising edge in IDLE where MREQ=1.
// While waiting, MREQ must stay high or the transfer is abandoned. ACKD_n is
// low for exactly one cycle per completed transfer, and the processor holds
// its request lines stable until that cycle has passed.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DAD,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  inout  wire  [31:0] DDT,
  output logic        ACKD_n,
  output logic        misalign,
  output logic [1:0]  fsm_state
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] req_index;
  logic [1:0]        req_lane;
  logic              req_write;
  logic [1:0]        req_size;
  logic [31:0]       req_data;
  logic [31:0]       rd_word;
  logic [31:0]       mem [DEPTH];

  logic              capture;
  logic              enter_ack;
  logic              ack_bad;
  logic [1:0]        cur_size;
  logic [1:0]        cur_lane;
  logic [ADDR_W-1:0] cur_index;
  logic              commit;
  logic [3:0]        byte_en;
  logic [31:0]       store_data;
  logic [31:0]       load_data;
  logic              drive;
  logic              unused_bits;

  // Upper address bits alias onto the RAM and are deliberately ignored.
  assign unused_bits = ^DAD[31:ADDR_W+2];
  assign fsm_state   = state;

  // Word needs lane 0, halfword needs an even lane, byte is always legal,
  // and size code 11 is reserved.
  function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   return lane != 2'b00;
      2'b01:   return lane[0];
      2'b10:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Decide whether this edge enters ACK, and pick the request fields that apply
  // (live bus in IDLE for the zero-wait case, captured copies otherwise).
  always_comb begin
    capture   = (state == S_IDLE) && MREQ;
    enter_ack = (capture && (WAIT_CYCLES == 0)) ||
                ((state == S_WAIT) && MREQ && (cnt == 4'd1));
    cur_size  = (state == S_IDLE) ? SIZE : req_size;
    cur_lane  = (state == S_IDLE) ? DAD[1:0] : req_lane;
    cur_index = (state == S_IDLE) ? DAD[ADDR_W+1:2] : req_index;
    ack_bad   = is_illegal(cur_size, cur_lane);
  end

  // Control FSM with registered ACKD_n / misalign and the request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      ACKD_n    <= 1'b1;
      misalign  <= 1'b0;
      req_index <= '0;
      req_lane  <= 2'b00;
      req_write <= 1'b0;
      req_size  <= 2'b00;
      req_data  <= 32'd0;
    end else begin
      ACKD_n   <= !enter_ack;
      misalign <= enter_ack && ack_bad;
      case (state)
        S_IDLE: begin
          if (MREQ) begin
            req_index <= DAD[ADDR_W+1:2];
            req_lane  <= DAD[1:0];
            req_write <= WRITE;
            req_size  <= SIZE;
            req_data  <= DDT;
            cnt       <= WAIT_INIT;
            state     <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!MREQ) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= S_ACK;
            end
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Big-endian lane steering: byte lane k of the address is bits [31-8k -: 8].
  always_comb begin
    byte_en    = 4'b0000;
    store_data = req_data;
    case (req_size)
      2'b00: byte_en = 4'b1111;
      2'b01: begin
        byte_en    = req_lane[1] ? 4'b0011 : 4'b1100;
        store_data = {2{req_data[15:0]}};
      end
      2'b10: begin
        byte_en    = 4'b1000 >> req_lane;
        store_data = {4{req_data[7:0]}};
      end
      default: byte_en = 4'b0000;
    endcase
    commit = (state == S_ACK) && req_write && !is_illegal(req_size, req_lane);
  end

  // RAM: store commits on the edge leaving ACK; read register loads entering ACK.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (commit && byte_en[b]) begin
        mem[req_index][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
    if (enter_ack) begin
      rd_word <= mem[cur_index];
    end
  end

  // Right-justify and zero-extend the addressed lanes of the read word.
  always_comb begin
    load_data = 32'd0;
    if (!is_illegal(req_size, req_lane)) begin
      case (req_size)
        2'b00:   load_data = rd_word;
        2'b01:   load_data = {16'd0, (req_lane[1] ? rd_word[15:0] : rd_word[31:16])};
        2'b10:   load_data = {24'd0, 8'(rd_word >> (8 * (3 - req_lane)))};
        default: load_data = 32'd0;
      endcase
    end
    drive = (state == S_ACK) && !req_write;
  end

  assign DDT = drive ? load_data : 32'bz;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 1, 3 and 0 wait
// states share the request lines but each has its own MREQ and data bus.
// Data buses are pulled up, so a released bus reads all ones.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dad;
  logic [31:0] wdata;
  logic        write;
  logic [1:0]  size;
  logic [2:0]  mreq;
  tri1  [31:0] ddt0, ddt1, ddt2;
  logic        ack0, ack1, ack2;
  logic        mis0, mis1, mis2;
  logic [1:0]  st0, st1, st2;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  assign ddt0 = (mreq[0] && write) ? wdata : 32'bz;
  assign ddt1 = (mreq[1] && write) ? wdata : 32'bz;
  assign ddt2 = (mreq[2] && write) ? wdata : 32'bz;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .DAD(dad), .MREQ(mreq[0]), .WRITE(write), .SIZE(size),
    .DDT(ddt0), .ACKD_n(ack0), .misalign(mis0), .fsm_state(st0));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .DAD(dad), .MREQ(mreq[1]), .WRITE(write), .SIZE(size),
    .DDT(ddt1), .ACKD_n(ack1), .misalign(mis1), .fsm_state(st1));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .DAD(dad), .MREQ(mreq[2]), .WRITE(write), .SIZE(size),
    .DDT(ddt2), .ACKD_n(ack2), .misalign(mis2), .fsm_state(st2));

  function automatic int wait_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic ack_of(input int i);
    case (i)
      0:       return ack0;
      1:       return ack1;
      default: return ack2;
    endcase
  endfunction

  function automatic logic mis_of(input int i);
    case (i)
      0:       return mis0;
      1:       return mis1;
      default: return mis2;
    endcase
  endfunction

  function automatic logic [31:0] ddt_of(input int i);
    case (i)
      0:       return ddt0;
      1:       return ddt1;
      default: return ddt2;
    endcase
  endfunction

  function automatic logic [1:0] st_of(input int i);
    case (i)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: one full transfer on instance i, checking latency, misalign,
  // load data and the return to idle.
  task automatic xfer(input int i, input logic wr, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_rd, input logic exp_mis, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    dad   = addr;
    write = wr;
    size  = sz;
    wdata = data;
    mreq[i] = 1'b1;
    do begin
      @(negedge clk);
      lat++;
    end while (ack_of(i) !== 1'b0 && lat < 20);
    check({tag, "_lat"}, 32'(lat), 32'(wait_of(i) + 1));
    check({tag, "_mis"}, {31'd0, mis_of(i)}, {31'd0, exp_mis});
    if (!wr) check({tag, "_data"}, ddt_of(i), exp_rd);
    mreq[i] = 1'b0;
    @(negedge clk);
    check({tag, "_ack_end"}, {31'd0, ack_of(i)}, 32'd1);
    check({tag, "_ddt_idle"}, ddt_of(i), RELEASED);
  endtask

  initial begin
    int lows;
    rst   = 1'b0;
    dad   = 32'd0;
    wdata = 32'd0;
    write = 1'b0;
    size  = 2'b00;
    mreq  = 3'b000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ack", {31'd0, ack_of(i)}, 32'd1);
      check("rst_mis", {31'd0, mis_of(i)}, 32'd0);
      check("rst_ddt", ddt_of(i), RELEASED);
      check("rst_state", {30'd0, st_of(i)}, 32'd0);
    end
    rst = 1'b1;

    // Word round trip
    xfer(0, 1'b1, 2'b00, 32'h100, 32'hDEAD_BEEF, 32'd0, 1'b0, "st100");
    xfer(0, 1'b0, 2'b00, 32'h100, 32'd0, 32'hDEAD_BEEF, 1'b0, "ld100");

    // Byte / halfword lanes
    xfer(0, 1'b1, 2'b00, 32'h20, 32'h0000_0000, 32'd0, 1'b0, "st20");
    xfer(0, 1'b1, 2'b10, 32'h21, 32'h0000_00AA, 32'd0, 1'b0, "stb21");
    xfer(0, 1'b1, 2'b01, 32'h22, 32'h0000_1234, 32'd0, 1'b0, "sth22");
    xfer(0, 1'b0, 2'b00, 32'h20, 32'd0, 32'h00AA_1234, 1'b0, "ld20");
    xfer(0, 1'b0, 2'b10, 32'h21, 32'd0, 32'h0000_00AA, 1'b0, "ldb21");
    xfer(0, 1'b0, 2'b01, 32'h22, 32'd0, 32'h0000_1234, 1'b0, "ldh22");
    xfer(0, 1'b0, 2'b10, 32'h23, 32'd0, 32'h0000_0034, 1'b0, "ldb23");
    xfer(0, 1'b0, 2'b01, 32'h20, 32'd0, 32'h0000_00AA, 1'b0, "ldh20");

    // Misaligned and reserved-size requests
    xfer(0, 1'b1, 2'b00, 32'h40, 32'h1122_3344, 32'd0, 1'b0, "st40");
    xfer(0, 1'b1, 2'b01, 32'h41, 32'h0000_FFFF, 32'd0, 1'b1, "sth41_bad");
    xfer(0, 1'b0, 2'b00, 32'h40, 32'd0, 32'h1122_3344, 1'b0, "ld40");
    xfer(0, 1'b1, 2'b10, 32'h43, 32'hFFFF_FF99, 32'd0, 1'b0, "stb43");
    xfer(0, 1'b1, 2'b11, 32'h40, 32'h0000_0000, 32'd0, 1'b1, "st40_rsv");
    xfer(0, 1'b0, 2'b00, 32'h40, 32'd0, 32'h1122_3399, 1'b0, "ld40b");
    xfer(0, 1'b0, 2'b00, 32'h42, 32'd0, 32'h0000_0000, 1'b1, "ld42_bad");
    xfer(0, 1'b0, 2'b11, 32'h40, 32'd0, 32'h0000_0000, 1'b1, "ld40_rsv");

    // Reset during WAIT of a store: discarded
    xfer(0, 1'b1, 2'b00, 32'h60, 32'h0BAD_C0DE, 32'd0, 1'b0, "st60");
    @(negedge clk);
    dad = 32'h60; write = 1'b1; size = 2'b00; wdata = 32'hCAFE_F00D; mreq[0] = 1'b1;
    @(negedge clk);
    check("rstw_state_pre", {30'd0, st0}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstw_ack", {31'd0, ack0}, 32'd1);
    check("rstw_state", {30'd0, st0}, 32'd0);
    @(negedge clk);
    mreq[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    xfer(0, 1'b0, 2'b00, 32'h60, 32'd0, 32'h0BAD_C0DE, 1'b0, "ld60");

    // Reset during ACK of a misaligned load: outputs released at once
    @(negedge clk);
    dad = 32'h62; write = 1'b0; size = 2'b00; mreq[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rsta_ack_pre", {31'd0, ack0}, 32'd0);
    check("rsta_mis_pre", {31'd0, mis0}, 32'd1);
    check("rsta_ddt_pre", ddt0, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rsta_ack", {31'd0, ack0}, 32'd1);
    check("rsta_mis", {31'd0, mis0}, 32'd0);
    check("rsta_ddt", ddt0, RELEASED);
    @(negedge clk);
    mreq[0] = 1'b0;
    rst = 1'b1;

    // Abort with three wait states
    xfer(1, 1'b1, 2'b00, 32'h80, 32'h1234_5678, 32'd0, 1'b0, "st80");
    xfer(1, 1'b0, 2'b00, 32'h80, 32'd0, 32'h1234_5678, 1'b0, "ld80");
    @(negedge clk);
    dad = 32'h80; write = 1'b1; size = 2'b00; wdata = 32'h0000_0055; mreq[1] = 1'b1;
    @(negedge clk);
    mreq[1] = 1'b0;
    lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack1 === 1'b0) lows++;
    end
    check("abort_no_ack", 32'(lows), 32'd0);
    check("abort_state", {30'd0, st1}, 32'd0);
    xfer(1, 1'b0, 2'b00, 32'h80, 32'd0, 32'h1234_5678, 1'b0, "ld80_after");

    // Zero wait, back-to-back loads with aliasing
    xfer(2, 1'b1, 2'b00, 32'h3FFC, 32'h5A5A_A5A5, 32'd0, 1'b0, "st3ffc");
    @(negedge clk);
    dad = 32'h3FFC; write = 1'b0; size = 2'b00; mreq[2] = 1'b1;
    @(negedge clk);
    check("b2b_ack1", {31'd0, ack2}, 32'd0);
    check("b2b_data1", ddt2, 32'h5A5A_A5A5);
    dad = 32'h3FFC + 32'h1000;
    @(negedge clk);
    check("b2b_gap_ack", {31'd0, ack2}, 32'd1);
    check("b2b_gap_ddt", ddt2, RELEASED);
    @(negedge clk);
    check("b2b_ack2", {31'd0, ack2}, 32'd0);
    check("b2b_data2", ddt2, 32'h5A5A_A5A5);
    mreq[2] = 1'b0;
    @(negedge clk);
    check("b2b_end_ack", {31'd0, ack2}, 32'd1);
    check("b2b_end_ddt", ddt2, RELEASED);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
